// File: rtl/dct_mac_unit_p.sv
// Pipelined signed multiply-accumulate for one DCT output term: TAPS products are summed,
// then rounded half-up, arithmetically shifted and saturated, with ready/valid on both sides.
module dct_mac_unit_p #(
    parameter int DATA_W     = 8,
    parameter int COEF_W     = 12,
    parameter int TAPS       = 8,
    parameter int ACC_W      = 24,
    parameter int FRAC_SHIFT = 10,
    parameter int OUT_W      = 12,
    localparam int CNT_W     = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] din,
    input  logic [COEF_W-1:0] coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  dout,
    output logic              dout_sat,
    output logic [CNT_W-1:0]  tap_cnt
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int RND_W  = ACC_W + 1;
    localparam int RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    // Half an output LSB; zero when no fractional bits are dropped.
    localparam logic signed [RND_W-1:0] RND_HALF =
        (FRAC_SHIFT > 0) ? (RND_W'(1) << RND_POS) : '0;
    localparam logic signed [RND_W-1:0] OUT_MAX = RND_W'((longint'(1) << (OUT_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    logic stall;
    logic accept;

    logic signed [PROD_W-1:0] din_x;
    logic signed [PROD_W-1:0] coef_x;
    logic signed [PROD_W-1:0] prod;

    logic                     s1_valid_q;
    logic                     s1_last_q;
    logic signed [PROD_W-1:0] s1_prod_q;

    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  sum;
    logic                     s2_done;

    logic                     fin_valid_q;
    logic signed [ACC_W-1:0]  fin_sum_q;

    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  r;
    logic [OUT_W-1:0]         r_out;
    logic                     r_clamp;

    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~rst & ~clr & ~stall;
        accept   = in_valid & in_ready;

        din_x  = PROD_W'($signed(din));
        coef_x = PROD_W'($signed(coef));
        prod   = din_x * coef_x;

        sum     = acc_q + ACC_W'(s1_prod_q);
        // A block is complete only if it was not aborted at this edge.
        s2_done = s1_valid_q & s1_last_q & ~clr;
    end

    always_comb begin
        rnd     = RND_W'(fin_sum_q) + RND_HALF;
        r       = rnd >>> FRAC_SHIFT;
        r_out   = r[OUT_W-1:0];
        r_clamp = 1'b0;
        if (r > OUT_MAX) begin
            r_out   = OUT_MAX[OUT_W-1:0];
            r_clamp = 1'b1;
        end else if (r < OUT_MIN) begin
            r_out   = OUT_MIN[OUT_W-1:0];
            r_clamp = 1'b1;
        end
    end

    // S1: product register and tap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_prod_q  <= '0;
            tap_cnt    <= '0;
        end else if (clr) begin
            s1_valid_q <= 1'b0;
            tap_cnt    <= '0;
        end else if (!stall) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_prod_q <= prod;
                s1_last_q <= (tap_cnt == LAST_TAP);
                tap_cnt   <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + CNT_W'(1);
            end
        end
    end

    // S2: accumulator; the completed sum is handed to the rounding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            fin_valid_q <= 1'b0;
            fin_sum_q   <= '0;
        end else begin
            if (clr) begin
                acc_q <= '0;
            end else if (!stall && s1_valid_q) begin
                acc_q <= s1_last_q ? '0 : sum;
            end
            if (!stall) begin
                fin_valid_q <= s2_done;
                if (s2_done) begin
                    fin_sum_q <= sum;
                end
            end
        end
    end

    // Output register: with no stall the slot is free (empty or being consumed this edge).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            dout      <= '0;
            dout_sat  <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_valid_q;
            if (fin_valid_q) begin
                dout     <= r_out;
                dout_sat <= r_clamp;
            end
        end
    end

endmodule

// File: tb/tb_dct_mac_unit_p.sv
// Directed bench for dct_mac_unit_p: a block-level arithmetic model with a result queue is
// compared against the DUT every cycle; literal per-block expectations pin the model.
module tb_dct_mac_unit_p;

    localparam int DATA_W     = 8;
    localparam int COEF_W     = 12;
    localparam int TAPS       = 8;
    localparam int ACC_W      = 24;
    localparam int FRAC_SHIFT = 10;
    localparam int OUT_W      = 12;
    localparam int CNT_W      = $clog2(TAPS);

    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] din;
    logic [COEF_W-1:0] coef;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  dout;
    logic              dout_sat;
    logic [CNT_W-1:0]  tap_cnt;

    always #5 clk = ~clk;

    dct_mac_unit_p #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .TAPS      (TAPS),
        .ACC_W     (ACC_W),
        .FRAC_SHIFT(FRAC_SHIFT),
        .OUT_W     (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din      (din),
        .coef     (coef),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout     (dout),
        .dout_sat (dout_sat),
        .tap_cnt  (tap_cnt)
    );

    // Pending result: 'left' counts unstalled edges until it must be presented.
    typedef struct {
        longint val;
        logic   sat;
        int     left;
    } res_t;

    typedef struct {
        longint val;
        logic   sat;
    } lit_t;

    res_t   exp_q[$];
    lit_t   lit_q[$];
    longint m_sum = 0;
    int     m_cnt = 0;
    bit     chk_en = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Spec arithmetic: wrap to ACC_W, round half up, shift, clamp.
    function automatic void model_result(input longint s, output longint v, output logic sat);
        longint w;
        longint r;
        longint hi;
        longint lo;
        w  = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
        r  = (FRAC_SHIFT == 0) ? w : ((w + (longint'(1) <<< (FRAC_SHIFT - 1))) >>> FRAC_SHIFT);
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        v   = r;
        if (r > hi) begin
            v   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            v   = lo;
            sat = 1'b1;
        end
    endfunction

    // Check the state left by the previous edge, then predict the coming edge.
    always @(negedge clk) begin
        bit     ov_e;
        bit     stall_e;
        bit     ir_e;
        res_t   e;
        lit_t   l;
        ov_e    = (exp_q.size() > 0) && (exp_q[0].left == 0);
        stall_e = ov_e && !out_ready;
        ir_e    = !rst && !clr && !stall_e;
        if (chk_en) begin
            check("out_valid", longint'(out_valid), longint'(ov_e));
            check("in_ready", longint'(in_ready), longint'(ir_e));
            check("tap_cnt", longint'(tap_cnt), longint'(m_cnt));
            if (ov_e) begin
                check("dout", longint'($signed(dout)), exp_q[0].val);
                check("dout_sat", longint'(dout_sat), longint'(exp_q[0].sat));
            end
        end
        if (rst) begin
            exp_q.delete();
            m_sum  = 0;
            m_cnt  = 0;
            chk_en = 1;
        end else begin
            if (ov_e && out_ready) void'(exp_q.pop_front());
            if (!stall_e) begin
                foreach (exp_q[i]) if (exp_q[i].left > 0) exp_q[i].left = exp_q[i].left - 1;
            end
            if (clr) begin
                m_sum = 0;
                m_cnt = 0;
            end else if (in_valid && ir_e) begin
                m_sum += longint'($signed(din)) * longint'($signed(coef));
                m_cnt++;
                if (m_cnt == TAPS) begin
                    model_result(m_sum, e.val, e.sat);
                    e.left = 2;
                    exp_q.push_back(e);
                    m_sum = 0;
                    m_cnt = 0;
                    if (lit_q.size() > 0) begin
                        l = lit_q.pop_front();
                        check("model_dout", e.val, l.val);
                        check("model_sat", longint'(e.sat), longint'(l.sat));
                    end else begin
                        fail_now("model_literal_missing");
                    end
                end
            end
        end
    end

    task automatic send_tap(input int d, input int c);
        bit done;
        done     = 0;
        din      = DATA_W'(d);
        coef     = COEF_W'(c);
        in_valid = 1'b1;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("tap_accept");
        in_valid = 1'b0;
    endtask

    task automatic run_block(input int d, input int c, input longint ev, input logic es);
        lit_t l;
        l.val = ev;
        l.sat = es;
        lit_q.push_back(l);
        for (int i = 0; i < TAPS; i++) send_tap(d, c);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b1;
        din       = DATA_W'(5);
        coef      = COEF_W'(7);
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_dout", longint'(dout), 0);
        check("rst_dout_sat", longint'(dout_sat), 0);
        check("rst_tap_cnt", longint'(tap_cnt), 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", longint'(in_ready), 1);
        @(posedge clk);
        #1;

        // Basic, rounding and saturation blocks, streamed back-to-back.
        run_block(1, 1024, 8, 1'b0);
        run_block(1, 64, 1, 1'b0);
        run_block(-1, 64, 0, 1'b0);
        run_block(1, -96, -1, 1'b0);
        run_block(-128, -2048, 2047, 1'b1);
        run_block(-128, 2047, -2047, 1'b0);
        drain();

        // Backpressure across three blocks.
        fork
            begin
                run_block(1, 1024, 8, 1'b0);
                run_block(2, 1024, 16, 1'b0);
                run_block(3, 1024, 24, 1'b0);
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    seen = out_valid;
                end
                if (!seen) fail_now("stall_wait_out_valid");
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Abort with clr while a sample is offered.
        for (int i = 0; i < 3; i++) send_tap(100, 100);
        din      = DATA_W'(100);
        coef     = COEF_W'(100);
        in_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_tap_cnt", longint'(tap_cnt), 0);
        run_block(1, 1024, 8, 1'b0);
        drain();

        // Same abort through rst.
        for (int i = 0; i < 3; i++) send_tap(100, 100);
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_mid_tap_cnt", longint'(tap_cnt), 0);
        run_block(1, 1024, 8, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
